if_fetch_ctrl: RTL and testbench

Sequencer between the IF stage and a byte-wide, synchronous-read instruction memory. It fetches the 32-bit instruction at the current PC as four byte reads and assembles them big-endian. It drives the IF-stage freeze so the PC advances only when a full instruction has been delivered and the downstream hazard unit permits it. Branch redirects abort an in-progress fetch and take priority over every other event.

---
 rtl/if_fetch_ctrl_if.sv | 23 ++
 rtl/if_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - byte-wide synchronous-read instruction memory bus
// Signals:
//   mem_rd     read strobe, one byte per strobed cycle
//   mem_addr   byte address, 0 whenever mem_rd is low
//   mem_rdata  read data, valid in the cycle after the strobe
// Modports: master (fetch sequencer side), slave (memory side).
interface if_fetch_ctrl_if;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer assembling 32-bit instructions from byte reads
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   pc, req_valid     fetch request for the instruction at pc
//   branch_taken      redirect; aborts any fetch and releases the IF freeze
//   hazard_freeze     downstream stall; holds a delivered instruction
//   mem               memory bus (master modport)
//   instr, instr_valid assembled big-endian instruction and its valid flag
//   freeze_if         IF-stage freeze (PC enable is ~freeze_if)
//   stall_cnt         saturating count of frozen cycles
module if_fetch_ctrl #(
    parameter int STALL_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic                req_valid,
    input  logic                branch_taken,
    input  logic                hazard_freeze,
    if_fetch_ctrl_if.master     mem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic                freeze_if,
    output logic [STALL_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [31:0] pc_lat;
    logic        accept;
    logic        rd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        instr_valid = 1'b0;
        freeze_if   = 1'b1;
        rd          = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !branch_taken) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                rd = (cnt < 3'd4);
                if (branch_taken) begin
                    state_next = IDLE;
                end else if (cnt == 3'd4) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                instr_valid = 1'b1;
                if (branch_taken || !hazard_freeze) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (branch_taken || (state == DONE && !hazard_freeze)) begin
            freeze_if = 1'b0;
        end
        // Reset overrides everything visible to the IF stage and the memory.
        if (!rst) begin
            rd        = 1'b0;
            freeze_if = 1'b1;
        end
    end

    assign mem.mem_rd   = rd;
    assign mem.mem_addr = rd ? (pc_lat + {29'd0, cnt}) : 32'd0;

    // Byte lane cnt-1 receives the data read in the previous cycle; a read
    // issued just before a branch returns while in IDLE and is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= 3'd0;
            pc_lat <= 32'd0;
            instr  <= 32'd0;
        end else if (accept) begin
            cnt    <= 3'd0;
            pc_lat <= pc;
            instr  <= 32'd0;
        end else if (state == FETCH && !branch_taken) begin
            cnt <= cnt + 3'd1;
            case (cnt)
                3'd1:    instr[31:24] <= mem.mem_rdata;
                3'd2:    instr[23:16] <= mem.mem_rdata;
                3'd3:    instr[15:8]  <= mem.mem_rdata;
                3'd4:    instr[7:0]   <= mem.mem_rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (freeze_if && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_sat = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        req_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        hazard_freeze = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        freeze_if;
    logic [15:0] stall_cnt;

    logic [31:0] sat_instr;
    logic        sat_valid;
    logic        sat_freeze;
    logic [3:0]  sat_stall;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:255];

    if_fetch_ctrl_if bus ();
    if_fetch_ctrl_if sat_bus ();

    if_fetch_ctrl #(.STALL_W(16)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .req_valid     (req_valid),
        .branch_taken  (branch_taken),
        .hazard_freeze (hazard_freeze),
        .mem           (bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .freeze_if     (freeze_if),
        .stall_cnt     (stall_cnt)
    );

    if_fetch_ctrl #(.STALL_W(4)) u_sat (
        .clk           (clk),
        .rst           (rst_sat),
        .pc            (32'd0),
        .req_valid     (1'b0),
        .branch_taken  (1'b0),
        .hazard_freeze (1'b0),
        .mem           (sat_bus),
        .instr         (sat_instr),
        .instr_valid   (sat_valid),
        .freeze_if     (sat_freeze),
        .stall_cnt     (sat_stall)
    );

    assign sat_bus.mem_rdata = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply a one-cycle request in IDLE and advance to the first DONE cycle (T+6).
    task automatic fetch_to_done(input logic [31:0] a);
        pc = a;
        req_valid = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (instr !== 32'd0) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", instr, 32'd0); end
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        vectors++;
        if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        vectors++;
        if (bus.mem_rd !== 1'b0 || bus.mem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_mem: got rd=%b addr=%h expected rd=0 addr=0", bus.mem_rd, bus.mem_addr); end
        vectors++;
        if (freeze_if !== 1'b1) begin miscompares++; $display("FAIL reset_freeze: got %b expected 1", freeze_if); end
    endtask

    task automatic test_basic_fetch;
        logic [7:0]  exp_rd  = 8'b0001_1110;
        logic [7:0]  exp_frz = 8'b1011_1111;
        logic [7:0]  exp_vld = 8'b0100_0000;
        logic [31:0] exp_addr [8] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0};
        int frz0 = 0;
        rst = 1'b1;
        pc = 32'd0;
        req_valid = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                tick();
                req_valid = 1'b0;
                #1;
            end
            vectors++;
            if (bus.mem_rd !== exp_rd[c]) begin miscompares++; $display("FAIL basic_rd[%0d]: got %b expected %b", c, bus.mem_rd, exp_rd[c]); end
            vectors++;
            if (bus.mem_addr !== exp_addr[c]) begin miscompares++; $display("FAIL basic_addr[%0d]: got %h expected %h", c, bus.mem_addr, exp_addr[c]); end
            vectors++;
            if (freeze_if !== exp_frz[c]) begin miscompares++; $display("FAIL basic_freeze[%0d]: got %b expected %b", c, freeze_if, exp_frz[c]); end
            vectors++;
            if (instr_valid !== exp_vld[c]) begin miscompares++; $display("FAIL basic_valid[%0d]: got %b expected %b", c, instr_valid, exp_vld[c]); end
            if (freeze_if === 1'b0) frz0++;
            if (c == 5) begin
                vectors++;
                if (stall_cnt !== 16'd5) begin miscompares++; $display("FAIL basic_stall_t5: got %0d expected 5", stall_cnt); end
            end
            if (c == 6) begin
                vectors++;
                if (instr !== 32'hE3A01005) begin miscompares++; $display("FAIL basic_instr: got %h expected E3A01005", instr); end
            end
            if (c == 7) begin
                vectors++;
                if (stall_cnt !== 16'd6) begin miscompares++; $display("FAIL basic_stall_t7: got %0d expected 6", stall_cnt); end
            end
        end
        vectors++;
        if (frz0 !== 1) begin miscompares++; $display("FAIL basic_freeze_low_cycles: got %0d expected 1", frz0); end
    endtask

    task automatic test_hazard_hold;
        fetch_to_done(32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            hazard_freeze = 1'b1;
            #1;
            vectors++;
            if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL hazard_valid[%0d]: got %b expected 1", i, instr_valid); end
            vectors++;
            if (instr !== 32'hE3A01005) begin miscompares++; $display("FAIL hazard_instr[%0d]: got %h expected E3A01005", i, instr); end
            vectors++;
            if (freeze_if !== 1'b1) begin miscompares++; $display("FAIL hazard_freeze[%0d]: got %b expected 1", i, freeze_if); end
        end
        tick();
        hazard_freeze = 1'b0;
        #1;
        vectors++;
        if (freeze_if !== 1'b0 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL hazard_release: got freeze=%b valid=%b expected freeze=0 valid=1", freeze_if, instr_valid); end
        tick();
        vectors++;
        if (freeze_if !== 1'b1 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL hazard_after: got freeze=%b valid=%b expected freeze=1 valid=0", freeze_if, instr_valid); end
    endtask

    task automatic test_branch_abort;
        int seen = 0;
        pc = 32'd8;
        req_valid = 1'b1;
        #1;
        tick();
        req_valid = 1'b0;
        #1;
        vectors++;
        if (instr !== 32'd0) begin miscompares++; $display("FAIL branch_instr_cleared: got %h expected 00000000", instr); end
        tick();
        tick();
        branch_taken = 1'b1;
        pc = 32'h40;
        #1;
        vectors++;
        if (freeze_if !== 1'b0) begin miscompares++; $display("FAIL branch_freeze: got %b expected 0", freeze_if); end
        vectors++;
        if (bus.mem_addr !== 32'd10) begin miscompares++; $display("FAIL branch_addr: got %h expected 0000000a", bus.mem_addr); end
        tick();
        branch_taken = 1'b0;
        #1;
        vectors++;
        if (bus.mem_rd !== 1'b0 || freeze_if !== 1'b1) begin miscompares++; $display("FAIL branch_idle: got rd=%b freeze=%b expected rd=0 freeze=1", bus.mem_rd, freeze_if); end
        for (int i = 0; i < 6; i++) begin
            if (instr_valid !== 1'b0) seen++;
            tick();
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL branch_no_valid: got %0d valid cycles expected 0", seen); end
        fetch_to_done(32'h40);
        vectors++;
        if (instr !== 32'hDEADBEEF || instr_valid !== 1'b1) begin miscompares++; $display("FAIL branch_refetch: got %h valid=%b expected DEADBEEF valid=1", instr, instr_valid); end
        tick();
    endtask

    task automatic test_wrap;
        logic [31:0] exp_addr [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        pc = 32'hFFFFFFFE;
        req_valid = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            tick();
            req_valid = 1'b0;
            #1;
            vectors++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== exp_addr[c]) begin miscompares++; $display("FAIL wrap_addr[%0d]: got rd=%b addr=%h expected rd=1 addr=%h", c, bus.mem_rd, bus.mem_addr, exp_addr[c]); end
        end
        tick();
        tick();
        vectors++;
        if (instr !== 32'hCAFEE3A0 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_instr: got %h valid=%b expected CAFEE3A0 valid=1", instr, instr_valid); end
        tick();
    endtask

    task automatic test_reset_mid_fetch;
        pc = 32'h40;
        req_valid = 1'b1;
        #1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.mem_rd !== 1'b0 || bus.mem_addr !== 32'd0 || freeze_if !== 1'b1) begin miscompares++; $display("FAIL rstmid_comb: got rd=%b addr=%h freeze=%b expected rd=0 addr=0 freeze=1", bus.mem_rd, bus.mem_addr, freeze_if); end
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (instr !== 32'd0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_instr: got %h valid=%b expected 00000000 valid=0", instr, instr_valid); end
        vectors++;
        if (stall_cnt !== 16'd0 || bus.mem_rd !== 1'b0) begin miscompares++; $display("FAIL rstmid_state: got stall=%0d rd=%b expected stall=0 rd=0", stall_cnt, bus.mem_rd); end
        fetch_to_done(32'd8);
        vectors++;
        if (instr !== 32'h11223344 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_refetch: got %h valid=%b expected 11223344 valid=1", instr, instr_valid); end
        tick();
    endtask

    task automatic test_saturation;
        rst_sat = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) begin
                vectors++;
                if (sat_stall !== 4'd14) begin miscompares++; $display("FAIL sat_14: got %0d expected 14", sat_stall); end
            end
            if (k == 15 || k == 20) begin
                vectors++;
                if (sat_stall !== 4'd15) begin miscompares++; $display("FAIL sat_%0d: got %0d expected 15", k, sat_stall); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hE3; mem[8'h01] = 8'hA0; mem[8'h02] = 8'h10; mem[8'h03] = 8'h05;
        mem[8'h08] = 8'h11; mem[8'h09] = 8'h22; mem[8'h0A] = 8'h33; mem[8'h0B] = 8'h44;
        mem[8'h40] = 8'hDE; mem[8'h41] = 8'hAD; mem[8'h42] = 8'hBE; mem[8'h43] = 8'hEF;
        mem[8'hFE] = 8'hCA; mem[8'hFF] = 8'hFE;

        test_reset();
        test_basic_fetch();
        test_hazard_hold();
        test_branch_abort();
        test_wrap();
        test_reset_mid_fetch();
        test_saturation();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
